// File: rtl/data_mem_ctrl_pkg.sv
// Shared encodings and helpers for the MEM-stage data memory controller.
package data_mem_pkg;

  localparam int unsigned SIZE_W = 2;
  localparam logic [SIZE_W-1:0] SZ_BYTE  = 2'b00;
  localparam logic [SIZE_W-1:0] SZ_HALF  = 2'b01;
  localparam logic [SIZE_W-1:0] SZ_WORD  = 2'b10;
  localparam logic [SIZE_W-1:0] SZ_DWORD = 2'b11;

  localparam int unsigned ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT = 2'd1;
  localparam logic [ST_W-1:0] ST_RESP = 2'd2;

  localparam int unsigned CNT_W = 4;

  // Access size in bytes for a size encoding.
  function automatic int unsigned size_bytes(input logic [SIZE_W-1:0] size);
    int unsigned one;
    one = 1;
    return one << size;
  endfunction

  // Extend right-justified lane data to 64 bits; dword passes through.
  function automatic logic [63:0] extend(input logic [63:0]       d,
                                         input logic [SIZE_W-1:0] size,
                                         input logic              sgn);
    logic [63:0] r;
    case (size)
      SZ_BYTE: r = {{56{sgn & d[7]}},  d[7:0]};
      SZ_HALF: r = {{48{sgn & d[15]}}, d[15:0]};
      SZ_WORD: r = {{32{sgn & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory (slave).
interface data_mem_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_ctrl_lane_align.sv
// Combinational lane logic: merges store bytes into a word and extracts/extends load data.
module mem_lane_align
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF    = 2
) (
  input  logic [OFF-1:0]    lane,
  input  logic [SIZE_W-1:0] size,
  input  logic              sgn,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] cur_word,
  output logic [DATA_W-1:0] st_word_c,
  output logic [DATA_W-1:0] ld_data_c
);

  localparam int unsigned SH_W = OFF + 3;

  logic [SH_W-1:0]   sh;
  logic [DATA_W-1:0] mask_base;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] rd_shift;

  assign sh = {lane, 3'b000};

  // Right-justified byte mask for the access size.
  always_comb begin
    mask_base = '1;
    case (size)
      SZ_BYTE: mask_base = DATA_W'(64'h0000_0000_0000_00FF);
      SZ_HALF: mask_base = DATA_W'(64'h0000_0000_0000_FFFF);
      SZ_WORD: mask_base = DATA_W'(64'h0000_0000_FFFF_FFFF);
      default: mask_base = '1;
    endcase
  end

  assign lane_mask = mask_base << sh;
  assign st_word_c = (cur_word & ~lane_mask) | ((wdata << sh) & lane_mask);
  assign rd_shift  = cur_word >> sh;
  assign ld_data_c = DATA_W'(extend(64'(rd_shift), size, sgn));

endmodule

// File: rtl/data_mem_ctrl.sv
// Handshaked single-port data memory with lane stores, extended loads and wait states.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned INIT_ZERO   = 1
) (
  input logic             clk,
  input logic             rst_n,
  data_mem_ctrl_if.slave  bus
);

  localparam int unsigned OFF   = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = ADDR_W - OFF;
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (!(DATA_W == 32 || DATA_W == 64)) begin : g_bad_data_w
    $error("data_mem_ctrl: DATA_W must be 32 or 64");
  end
  if (WAIT_STATES > 15 || INIT_ZERO > 1) begin : g_bad_params
    $error("data_mem_ctrl: WAIT_STATES must be 0..15 and INIT_ZERO 0 or 1");
  end

  logic [ST_W-1:0]   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              r_write, r_signed;
  logic [SIZE_W-1:0] r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic              accept_c, commit_c, mem_we_c;
  logic              e_write, e_signed, e_err;
  logic [SIZE_W-1:0] e_size;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic [IDX_W-1:0]  e_idx;
  logic [OFF-1:0]    e_lane;
  logic [DATA_W-1:0] cur_word, st_word_c, ld_data_c;

  logic [DATA_W-1:0] mem [DEPTH];

  assign accept_c = bus.req_valid & ready_q;

  // With no wait states the commit edge is the accept edge, so the live request is used.
  assign e_write  = accept_c ? bus.req_write  : r_write;
  assign e_signed = accept_c ? bus.req_signed : r_signed;
  assign e_size   = accept_c ? bus.req_size   : r_size;
  assign e_addr   = accept_c ? bus.req_addr   : r_addr;
  assign e_wdata  = accept_c ? bus.req_wdata  : r_wdata;

  assign e_idx  = e_addr[ADDR_W-1:OFF];
  assign e_lane = e_addr[OFF-1:0];
  assign e_err  = (e_idx >= IDX_W'(DEPTH))
                | ((e_lane & OFF'(size_bytes(e_size) - 1)) != '0)
                | ((DATA_W == 32) && (e_size == SZ_DWORD));

  assign cur_word = mem[e_idx[AW-1:0]];

  mem_lane_align #(
    .DATA_W (DATA_W),
    .OFF    (OFF)
  ) u_align (
    .lane      (e_lane),
    .size      (e_size),
    .sgn       (e_signed),
    .wdata     (e_wdata),
    .cur_word  (cur_word),
    .st_word_c (st_word_c),
    .ld_data_c (ld_data_c)
  );

  // Next state, wait counter and response values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    commit_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (state_q == ST_RESP) state_d = ST_IDLE;
        if (accept_c) begin
          if (WAIT_STATES == 0) begin
            state_d  = ST_RESP;
            commit_c = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d  = ST_RESP;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d     = (state_d != ST_WAIT);
    rsp_valid_d = commit_c;
    rsp_err_d   = commit_c & e_err;
    rsp_rdata_d = (commit_c && !e_err && !e_write) ? ld_data_c : '0;
  end

  // rst_n gates the write so a reset-time request can never reach the array.
  assign mem_we_c = commit_c & ~e_err & e_write & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      r_write     <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (accept_c) begin
        r_write  <= bus.req_write;
        r_signed <= bus.req_signed;
        r_size   <= bus.req_size;
        r_addr   <= bus.req_addr;
        r_wdata  <= bus.req_wdata;
      end
    end
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[e_idx[AW-1:0]] <= st_word_c;
  end

  assign bus.req_ready = ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
